clk_div_ctrl: RTL and testbench

Runtime-reconfigurable clock divider controller. It generates a divided clock `clk_out` from `clk` and owns the divide ratio. Software or upstream logic requests ratio changes through a valid/ready config port. The block starts, stops and retunes the divider only at period boundaries, so `clk_out` never shows a runt or stretched pulse.

---
 rtl/clk_div_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_ctrl
//  Description : Runtime-reconfigurable clock divider. Produces a registered
//                divided clock clk_out (high H = N>>1 cycles, low N-H cycles)
//                and changes ratio, starts or stops only at period boundaries,
//                so clk_out never shows a runt or stretched pulse.
//  Ports       : clk        - system clock, rising-edge active
//                reset      - asynchronous active-high reset
//                en         - run (1) / stop at next boundary (0)
//                cfg_valid  - ratio change request valid
//                cfg_div    - requested divide ratio N
//                cfg_ready  - request can be accepted (not in PEND)
//                cfg_done   - 1-cycle pulse when an accepted ratio takes effect
//                cfg_err    - 1-cycle pulse when an accepted ratio is < 2
//                cur_div    - ratio currently in force
//                clk_out    - divided clock
//                tick       - 1-cycle pulse on the first cycle of each period
//                running    - 1 while RUN or PEND
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] cur_div,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    localparam logic [1:0] c_st_off  = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_pend = 2'd2;

    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_min_div     = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    logic [1:0]       r_state,    w_state_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic [CNT_W-1:0] r_cur_div,  w_cur_div_nxt;
    logic [CNT_W-1:0] r_pend_div, w_pend_div_nxt;
    logic             r_clk_out,  w_clk_out_nxt;
    logic             r_tick,     w_tick_nxt;
    logic             r_cfg_done, w_cfg_done_nxt;
    logic             r_cfg_err,  w_cfg_err_nxt;

    logic             w_accept;
    logic             w_bad_div;
    logic             w_good;
    logic             w_last;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_cnt_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_off;
            r_cnt      <= '0;
            r_cur_div  <= c_default_div;
            r_pend_div <= '0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
            r_cfg_done <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur_div  <= w_cur_div_nxt;
            r_pend_div <= w_pend_div_nxt;
            r_clk_out  <= w_clk_out_nxt;
            r_tick     <= w_tick_nxt;
            r_cfg_done <= w_cfg_done_nxt;
            r_cfg_err  <= w_cfg_err_nxt;
        end
    end

    always_comb begin
        w_accept  = cfg_valid && (r_state != c_st_pend);
        w_bad_div = (cfg_div < c_min_div);
        w_good    = w_accept && !w_bad_div;
        w_last    = (r_cnt == (r_cur_div - c_one));
        w_half    = r_cur_div >> 1;
        w_cnt_inc = r_cnt + c_one;

        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cur_div_nxt  = r_cur_div;
        w_pend_div_nxt = r_pend_div;
        w_clk_out_nxt  = r_clk_out;
        w_tick_nxt     = 1'b0;
        w_cfg_done_nxt = 1'b0;
        // A rejected ratio only raises the error pulse; nothing else moves.
        w_cfg_err_nxt  = w_accept && w_bad_div;

        case (r_state)
            c_st_off: begin
                w_cnt_nxt     = '0;
                w_clk_out_nxt = 1'b0;
                if (w_good) begin
                    w_cur_div_nxt  = cfg_div;
                    w_cfg_done_nxt = 1'b1;
                end
                if (en) begin
                    w_state_nxt   = c_st_run;
                    w_clk_out_nxt = 1'b1;
                    w_tick_nxt    = 1'b1;
                end
            end
            c_st_run, c_st_pend: begin
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (r_state == c_st_pend) begin
                        w_cur_div_nxt  = r_pend_div;
                        w_cfg_done_nxt = 1'b1;
                    end else if (w_good) begin
                        // Request landing on the boundary applies immediately.
                        w_cur_div_nxt  = cfg_div;
                        w_cfg_done_nxt = 1'b1;
                    end
                    if (en) begin
                        // H >= 1 for every legal ratio, so a new period
                        // always starts high.
                        w_state_nxt   = c_st_run;
                        w_clk_out_nxt = 1'b1;
                        w_tick_nxt    = 1'b1;
                    end else begin
                        w_state_nxt   = c_st_off;
                        w_clk_out_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt     = w_cnt_inc;
                    w_clk_out_nxt = (w_cnt_inc < w_half);
                    if ((r_state == c_st_run) && w_good) begin
                        w_pend_div_nxt = cfg_div;
                        w_state_nxt    = c_st_pend;
                    end
                end
            end
            default: begin
                w_state_nxt   = c_st_off;
                w_cnt_nxt     = '0;
                w_clk_out_nxt = 1'b0;
            end
        endcase
    end

    assign cfg_ready = (r_state != c_st_pend);
    assign running   = (r_state == c_st_run) || (r_state == c_st_pend);
    assign cfg_done  = r_cfg_done;
    assign cfg_err   = r_cfg_err;
    assign cur_div   = r_cur_div;
    assign clk_out   = r_clk_out;
    assign tick      = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_ctrl
//  Description : Directed self-checking bench for clk_div_ctrl. A small
//                period model (phase, ratio in force, next ratio) gives the
//                expected clk_out / tick on every cycle; handshake outputs are
//                checked against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

    localparam int CNT_W = 8;

    logic             r_clk = 1'b0;
    logic             r_reset;
    logic             r_en;
    logic             r_cfg_valid;
    logic [CNT_W-1:0] r_cfg_div;
    logic             w_cfg_ready;
    logic             w_cfg_done;
    logic             w_cfg_err;
    logic [CNT_W-1:0] w_cur_div;
    logic             w_clk_out;
    logic             w_tick;
    logic             w_running;

    int n_checks = 0;
    int n_fails  = 0;
    int m_ph     = 0;
    int m_n      = 4;
    int m_next   = 4;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) u_dut (
        .clk       (r_clk),
        .reset     (r_reset),
        .en        (r_en),
        .cfg_valid (r_cfg_valid),
        .cfg_div   (r_cfg_div),
        .cfg_ready (w_cfg_ready),
        .cfg_done  (w_cfg_done),
        .cfg_err   (w_cfg_err),
        .cur_div   (w_cur_div),
        .clk_out   (w_clk_out),
        .tick      (w_tick),
        .running   (w_running)
    );

    always #20 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle of the period model and compare the waveform.
    task automatic cyc();
        @(negedge r_clk);
        if (m_ph == m_n - 1) begin
            m_ph = 0;
            m_n  = m_next;
        end else begin
            m_ph = m_ph + 1;
        end
        check("clk_out", 32'(w_clk_out), 32'(m_ph < m_n / 2));
        check("tick", 32'(w_tick), 32'(m_ph == 0));
        check("running", 32'(w_running), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        r_reset     = 1'b1;
        r_en        = 1'b0;
        r_cfg_valid = 1'b0;
        r_cfg_div   = '0;

        // Reset state
        #5;
        check("rst_clk_out", 32'(w_clk_out), 32'd0);
        check("rst_cur_div", 32'(w_cur_div), 32'd4);
        check("rst_ready", 32'(w_cfg_ready), 32'd1);
        check("rst_running", 32'(w_running), 32'd0);
        check("rst_tick", 32'(w_tick), 32'd0);
        check("rst_done", 32'(w_cfg_done), 32'd0);
        check("rst_err", 32'(w_cfg_err), 32'd0);
        #19 r_reset = 1'b0;

        // Start at N=4: 2 high / 2 low, tick every 4
        @(negedge r_clk);
        check("off_clk_out", 32'(w_clk_out), 32'd0);
        r_en = 1'b1;
        m_n = 4; m_next = 4; m_ph = 3;
        for (int i = 0; i < 8; i++) cyc();
        check("n4_cur_div", 32'(w_cur_div), 32'd4);

        // Change to 7 accepted at cnt=1
        cyc();
        cyc();
        check("acc7_ready", 32'(w_cfg_ready), 32'd1);
        r_cfg_valid = 1'b1; r_cfg_div = 8'd7; m_next = 7;
        cyc();
        r_cfg_valid = 1'b0;
        check("pend_ready2", 32'(w_cfg_ready), 32'd0);
        check("pend_done2", 32'(w_cfg_done), 32'd0);
        cyc();
        check("pend_ready3", 32'(w_cfg_ready), 32'd0);
        check("pend_cur3", 32'(w_cur_div), 32'd4);
        cyc();
        check("n7_done", 32'(w_cfg_done), 32'd1);
        check("n7_cur_div", 32'(w_cur_div), 32'd7);
        check("n7_ready", 32'(w_cfg_ready), 32'd1);
        for (int i = 0; i < 13; i++) begin
            cyc();
            check("n7_done_low", 32'(w_cfg_done), 32'd0);
        end

        // Rejected ratios 1 and 0
        cyc();
        r_cfg_valid = 1'b1; r_cfg_div = 8'd1;
        cyc();
        r_cfg_valid = 1'b0;
        check("err1", 32'(w_cfg_err), 32'd1);
        check("err1_ready", 32'(w_cfg_ready), 32'd1);
        cyc();
        check("err1_clear", 32'(w_cfg_err), 32'd0);
        r_cfg_valid = 1'b1; r_cfg_div = 8'd0;
        cyc();
        r_cfg_valid = 1'b0;
        check("err0", 32'(w_cfg_err), 32'd1);
        cyc();
        check("err0_clear", 32'(w_cfg_err), 32'd0);
        check("err_cur_div", 32'(w_cur_div), 32'd7);
        check("err_done", 32'(w_cfg_done), 32'd0);
        cyc(); cyc(); cyc();

        // Move to N=6, then drop en at cnt=0
        r_cfg_valid = 1'b1; r_cfg_div = 8'd6; m_next = 6;
        cyc();
        r_cfg_valid = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        cyc();
        check("n6_done", 32'(w_cfg_done), 32'd1);
        check("n6_cur_div", 32'(w_cur_div), 32'd6);
        r_en = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        @(negedge r_clk);
        check("stop_clk_out", 32'(w_clk_out), 32'd0);
        check("stop_running", 32'(w_running), 32'd0);
        check("stop_tick", 32'(w_tick), 32'd0);
        @(negedge r_clk);
        check("stop_clk_out2", 32'(w_clk_out), 32'd0);
        check("stop_tick2", 32'(w_tick), 32'd0);

        // Ratio 2 loaded while OFF, then run
        r_cfg_valid = 1'b1; r_cfg_div = 8'd2;
        @(negedge r_clk);
        r_cfg_valid = 1'b0;
        check("off_done", 32'(w_cfg_done), 32'd1);
        check("off_tick", 32'(w_tick), 32'd0);
        check("off_cur_div", 32'(w_cur_div), 32'd2);
        check("off_running", 32'(w_running), 32'd0);
        r_en = 1'b1;
        m_n = 2; m_next = 2; m_ph = 1;
        cyc();
        check("n2_done_low", 32'(w_cfg_done), 32'd0);
        for (int i = 0; i < 5; i++) cyc();

        // 2 -> 4, then 4 -> 9 interrupted by reset
        cyc();
        r_cfg_valid = 1'b1; r_cfg_div = 8'd4; m_next = 4;
        cyc();
        r_cfg_valid = 1'b0;
        check("p4_ready", 32'(w_cfg_ready), 32'd0);
        cyc();
        check("n4b_done", 32'(w_cfg_done), 32'd1);
        check("n4b_cur_div", 32'(w_cur_div), 32'd4);
        cyc();
        r_cfg_valid = 1'b1; r_cfg_div = 8'd9;
        cyc();
        r_cfg_valid = 1'b0;
        check("p9_ready", 32'(w_cfg_ready), 32'd0);
        #5 r_reset = 1'b1;
        #1;
        check("arst_clk_out", 32'(w_clk_out), 32'd0);
        check("arst_cur_div", 32'(w_cur_div), 32'd4);
        check("arst_ready", 32'(w_cfg_ready), 32'd1);
        check("arst_running", 32'(w_running), 32'd0);
        @(negedge r_clk);
        check("arst_hold_clk", 32'(w_clk_out), 32'd0);
        r_reset = 1'b0;
        m_n = 4; m_next = 4; m_ph = 3;
        for (int i = 0; i < 8; i++) cyc();
        check("post_cur_div", 32'(w_cur_div), 32'd4);
        check("post_done", 32'(w_cfg_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
